exec_mem_stage: RTL and testbench
=================================

// Module: exec_mem_stage
// PURPOSE
//  Execute + data-memory stage of the single-cycle RV32 datapath: ALU-control decode, 32-bit ALU,
//  word-addressed data RAM. Sits after register file/immediate generator and before write-back.
//  Produces ALU result, zero/overflow flags and memory read data. Write-back select stays outside.
// PARAMETERS
//  DATA_W  32    datapath width
//  ADDR_W  10    RAM word-address width, taken from alu_out[ADDR_W-1:0]
//  DEPTH   1024  RAM words (2**ADDR_W)
// PORTS
//  clk       in   1       rising-edge clock; RAM writes only
//  reset     in   1       asynchronous, active-high
//  aluop     in   2       from main control: 00 load/store, 01 branch, 10 R-type, 11 reserved
//  funct7    in   7       instruction[31:25]
//  funct3    in   3       instruction[14:12]
//  a         in   DATA_W  rs1 data, ALU operand A
//  b         in   DATA_W  ALU operand B, already muxed (rs2 or immediate)
//  wdata     in   DATA_W  rs2 data, store data
//  memread   in   1       enable read data
//  memwrite  in   1       write wdata at the next rising clk
//  aluctl    out  4       decoded ALU operation
//  alu_out   out  DATA_W  ALU result; also the memory address
//  zero      out  1       alu_out == 0
//  overflow  out  1       signed overflow on ADD/SUB, else 0
//  readdata  out  DATA_W  RAM read data
// BEHAVIOUR
//  ALU control (combinational):
//  - aluop 00 -> 0010 ADD; 01 -> 0110 SUB; 11 -> 0010 ADD.
//  - aluop 10, keyed on {funct7[5],funct3}: 0_000 -> 0010 ADD; 1_000 -> 0110 SUB;
//    x_111 -> 0000 AND; x_110 -> 0001 OR; x_010 -> 0111 SLT; any other -> 0010 ADD.
//  ALU (combinational):
//  - 0000 a&b; 0001 a|b; 0010 a+b; 0110 a-b; 0111 (signed a<b) ? 1 : 0; 1100 ~(a|b).
//  - Any other code -> 0.
//  - ADD/SUB wrap modulo 2^32.
//  - overflow = operand signs produce a wrong result sign (ADD: like signs in, opposite sign out;
//    SUB: a and b signs differ and result sign differs from a). overflow = 0 for non-arithmetic ops.
//  - zero = ~|alu_out, valid for every op.
//  Data RAM:
//  - DEPTH x DATA_W words; word index = alu_out[ADDR_W-1:0]; upper address bits ignored (wrap).
//  - Write: on the rising clk edge when memwrite=1 and reset=0, mem[idx] <= wdata.
//  - Read: combinational, readdata = memread ? mem[idx] : 0. Zero latency.
//    A same-cycle read of a location being written returns the old value until the edge.
//  - memread=memwrite=1: both take effect; the read returns the pre-write contents.
//  Reset:
//  - Reset asserted asynchronously clears every RAM word to 0 and blocks writes.
//  - While reset=1, readdata = 0. All other outputs remain purely combinational.
//  - Reset asserted mid-write: the write is dropped.
// TESTING
//  1 aluop=10, funct7=0x00, funct3=000, a=5, b=7 -> aluctl=0010, alu_out=12, zero=0, overflow=0
//  2 aluop=01, a=b=0x1234 -> aluctl=0110, alu_out=0, zero=1; a=0x7FFFFFFF, b=0xFFFFFFFF
//    (SUB) -> overflow=1
//  3 aluop=10: funct3=111, a=0xF0F0, b=0xFF00 -> 0xF000; funct3=110 -> 0xFFF0;
//    funct3=010, a=-1, b=1 -> alu_out=1
//  4 aluop=00, a=4, b=8, wdata=0xDEADBEEF, memwrite=1, one clk, then memwrite=0, memread=1
//    -> readdata=0xDEADBEEF; memread=0 -> readdata=0
//  5 Address wrap: write 0x55 with alu_out=0x400 -> readable at alu_out=0
//  6 Write word 3, assert reset between edges -> readdata=0 immediately;
//    after release, word 3 reads 0

Source files
------------

// File: rtl/exec_mem_stage.sv
// -----------------------------------------------------------------------------
// exec_mem_stage
//   Execute + data-memory stage of a single-cycle RV32 datapath.
//   Decodes the ALU operation from main-control aluop and funct7/funct3,
//   runs the 32-bit ALU, and accesses a word-addressed data RAM using the
//   low ADDR_W bits of the ALU result as the word index. Write-back
//   selection stays outside this block.
//
// Ports
//   clk       in   1       rising-edge clock, used only for RAM writes
//   reset     in   1       asynchronous, active-high; clears the RAM
//   aluop     in   2       00 load/store, 01 branch, 10 R-type, 11 reserved
//   funct7    in   7       instruction[31:25]
//   funct3    in   3       instruction[14:12]
//   a         in   DATA_W  ALU operand A (rs1)
//   b         in   DATA_W  ALU operand B (rs2 or immediate, already muxed)
//   wdata     in   DATA_W  store data (rs2)
//   memread   in   1       enables readdata
//   memwrite  in   1       writes wdata at the next rising clk
//   aluctl    out  4       decoded ALU operation
//   alu_out   out  DATA_W  ALU result, also the memory address
//   zero      out  1       alu_out == 0
//   overflow  out  1       signed overflow on ADD/SUB, else 0
//   readdata  out  DATA_W  combinational RAM read data
// -----------------------------------------------------------------------------
module exec_mem_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        aluop,
  input  logic [6:0]        funct7,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] wdata,
  input  logic              memread,
  input  logic              memwrite,
  output logic [3:0]        aluctl,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero,
  output logic              overflow,
  output logic [DATA_W-1:0] readdata
);

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_op_e;

  localparam int MSB = DATA_W - 1;

  alu_op_e alu_op;

  // Only funct7[5] distinguishes ADD from SUB; the remaining bits are unused.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // ---------------------------------------------------------------------------
  // ALU control decode
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_op = ALU_ADD;
    case (aluop)
      2'b01:   alu_op = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
          3'b111:  alu_op = ALU_AND;
          3'b110:  alu_op = ALU_OR;
          3'b010:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      default: alu_op = ALU_ADD;  // load/store and the reserved encoding
    endcase
  end

  assign aluctl = alu_op;

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    alu_out  = '0;
    overflow = 1'b0;
    case (alu_op)
      ALU_AND: alu_out = a & b;
      ALU_OR:  alu_out = a | b;
      ALU_ADD: begin
        alu_out  = sum;
        // Like-signed operands whose sum flips sign.
        overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        alu_out  = diff;
        // Unlike-signed operands whose difference takes b's sign.
        overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      ALU_SLT: alu_out = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOR: alu_out = ~(a | b);
      default: alu_out = '0;
    endcase
  end

  assign zero = ~|alu_out;

  // ---------------------------------------------------------------------------
  // Data RAM: synchronous write, combinational read. Upper address bits are
  // ignored, so addresses wrap every DEPTH words.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] idx;

  assign idx = alu_out[ADDR_W-1:0];

  // NOTE: the RAM is deliberately reset (it is flop-based, not a macro) so that
  // an asserted reset clears every word and drops any write in flight; state
  // updates use non-blocking assignments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (memwrite) begin
      mem_q[idx] <= wdata;
    end
  end

  // Reads see the contents before any write on the coming edge.
  assign readdata = (memread && !reset) ? mem_q[idx] : '0;

endmodule

// File: tb/tb_exec_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_exec_mem_stage
//   Self-checking bench for exec_mem_stage: directed cases followed by
//   randomized traffic, all compared against a behavioural reference model
//   (integer arithmetic for the ALU, a plain array for the RAM).
// -----------------------------------------------------------------------------
module tb_exec_mem_stage;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        aluop;
  logic [6:0]        funct7;
  logic [2:0]        funct3;
  logic [DATA_W-1:0] a, b, wdata;
  logic              memread, memwrite;
  logic [3:0]        aluctl;
  logic [DATA_W-1:0] alu_out;
  logic              zero, overflow;
  logic [DATA_W-1:0] readdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model_mem [DEPTH];

  exec_mem_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .aluop    (aluop),
    .funct7   (funct7),
    .funct3   (funct3),
    .a        (a),
    .b        (b),
    .wdata    (wdata),
    .memread  (memread),
    .memwrite (memwrite),
    .aluctl   (aluctl),
    .alu_out  (alu_out),
    .zero     (zero),
    .overflow (overflow),
    .readdata (readdata)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] ref_ctl(input logic [1:0] op, input logic [6:0] f7,
                                         input logic [2:0] f3);
    if (op == 2'b01) return 4'b0110;
    if (op != 2'b10) return 4'b0010;
    if (f3 == 3'b000) return f7[5] ? 4'b0110 : 4'b0010;
    if (f3 == 3'b111) return 4'b0000;
    if (f3 == 3'b110) return 4'b0001;
    if (f3 == 3'b010) return 4'b0111;
    return 4'b0010;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] ctl, input logic [31:0] x,
                                          input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    if (ctl == 4'b0000) return x & y;
    if (ctl == 4'b0001) return x | y;
    if (ctl == 4'b0010) return 32'((sx + sy) % 64'sh1_0000_0000);
    if (ctl == 4'b0110) return 32'((sx - sy) % 64'sh1_0000_0000);
    if (ctl == 4'b0111) return (sx < sy) ? 32'd1 : 32'd0;
    if (ctl == 4'b1100) return ~(x | y);
    return 32'd0;
  endfunction

  // Overflow: the exact signed result does not fit in 32 bits.
  function automatic logic ref_ovf(input logic [3:0] ctl, input logic [31:0] x,
                                   input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint r;
    if (ctl == 4'b0010)      r = sx + sy;
    else if (ctl == 4'b0110) r = sx - sy;
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  function automatic int ref_idx();
    logic [31:0] r = ref_alu(ref_ctl(aluop, funct7, funct3), a, b);
    return int'(r % DEPTH);
  endfunction

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Compare every combinational output against the model for the current inputs.
  task automatic check_all(input string tag);
    logic [3:0]  e_ctl = ref_ctl(aluop, funct7, funct3);
    logic [31:0] e_res = ref_alu(e_ctl, a, b);
    logic [31:0] e_rd  = (memread && !reset) ? model_mem[int'(e_res % DEPTH)] : 32'd0;
    check({tag, ".aluctl"},   {28'd0, aluctl},   {28'd0, e_ctl});
    check({tag, ".alu_out"},  alu_out,           e_res);
    check({tag, ".zero"},     {31'd0, zero},     {31'd0, (e_res == 32'd0)});
    check({tag, ".overflow"}, {31'd0, overflow}, {31'd0, ref_ovf(e_ctl, a, b)});
    check({tag, ".readdata"}, readdata,          e_rd);
  endtask

  task automatic drive(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] x, input logic [31:0] y, input logic [31:0] wd,
                       input logic mr, input logic mw);
    aluop = op; funct7 = f7; funct3 = f3;
    a = x; b = y; wdata = wd;
    memread = mr; memwrite = mw;
    #1;
  endtask

  // Advance one clock: model the write at the rising edge, return to the
  // falling edge where inputs change.
  task automatic step();
    int i;
    @(posedge clk);
    i = ref_idx();
    if (!reset && memwrite) model_mem[i] = wdata;
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    model_reset();
    reset = 1'b1;
    drive(2'b00, 7'h00, 3'b000, 32'd4, 32'd8, 32'h0, 1'b1, 1'b0);
    check("reset_readdata", readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all("after_reset");

    // Directed: R-type ADD
    drive(2'b10, 7'h00, 3'b000, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0);
    check_all("add_5_7");
    check("add_5_7.exp", alu_out, 32'd12);

    // Directed: branch SUB equal operands, then SUB overflow
    drive(2'b01, 7'h00, 3'b000, 32'h1234, 32'h1234, 32'd0, 1'b0, 1'b0);
    check_all("beq_equal");
    check("beq_equal.zero", {31'd0, zero}, 32'd1);
    drive(2'b01, 7'h00, 3'b000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    check_all("sub_ovf");
    check("sub_ovf.flag", {31'd0, overflow}, 32'd1);

    // Directed: AND / OR / SLT / R-type SUB / ADD overflow
    drive(2'b10, 7'h00, 3'b111, 32'hF0F0, 32'hFF00, 32'd0, 1'b0, 1'b0);
    check_all("and");
    check("and.exp", alu_out, 32'hF000);
    drive(2'b10, 7'h00, 3'b110, 32'hF0F0, 32'hFF00, 32'd0, 1'b0, 1'b0);
    check_all("or");
    check("or.exp", alu_out, 32'hFFF0);
    drive(2'b10, 7'h00, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
    check_all("slt_neg");
    check("slt_neg.exp", alu_out, 32'd1);
    drive(2'b10, 7'h20, 3'b000, 32'd3, 32'd10, 32'd0, 1'b0, 1'b0);
    check_all("rsub");
    drive(2'b11, 7'h20, 3'b000, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
    check_all("add_ovf_reserved");
    check("add_ovf.flag", {31'd0, overflow}, 32'd1);
    drive(2'b10, 7'h00, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
    check_all("funct3_other_add");

    // Directed: store then load at address 12
    drive(2'b00, 7'h00, 3'b010, 32'd4, 32'd8, 32'hDEAD_BEEF, 1'b0, 1'b1);
    check_all("store12");
    step();
    drive(2'b00, 7'h00, 3'b010, 32'd4, 32'd8, 32'h0, 1'b1, 1'b0);
    check_all("load12");
    check("load12.exp", readdata, 32'hDEAD_BEEF);
    drive(2'b00, 7'h00, 3'b010, 32'd4, 32'd8, 32'h0, 1'b0, 1'b0);
    check("load12_noread", readdata, 32'd0);

    // Directed: read-during-write returns the old contents until the edge
    drive(2'b00, 7'h00, 3'b010, 32'd4, 32'd8, 32'h1111_2222, 1'b1, 1'b1);
    check("rdw_old", readdata, 32'hDEAD_BEEF);
    step();
    drive(2'b00, 7'h00, 3'b010, 32'd4, 32'd8, 32'h0, 1'b1, 1'b0);
    check("rdw_new", readdata, 32'h1111_2222);

    // Directed: address wrap (0x400 aliases word 0) and top word
    drive(2'b00, 7'h00, 3'b010, 32'h400, 32'd0, 32'h55, 1'b0, 1'b1);
    step();
    drive(2'b00, 7'h00, 3'b010, 32'd0, 32'd0, 32'h0, 1'b1, 1'b0);
    check("wrap_word0", readdata, 32'h55);
    drive(2'b00, 7'h00, 3'b010, 32'h3FF, 32'd0, 32'hA5A5_0001, 1'b0, 1'b1);
    step();
    drive(2'b00, 7'h00, 3'b010, 32'hFFFF_FFFF, 32'd0, 32'h0, 1'b1, 1'b0);
    check("top_word_alias", readdata, 32'hA5A5_0001);

    // Directed: reset between edges clears RAM and drops a pending write
    drive(2'b00, 7'h00, 3'b010, 32'd3, 32'd0, 32'hCAFE_F00D, 1'b0, 1'b1);
    step();
    drive(2'b00, 7'h00, 3'b010, 32'd3, 32'd0, 32'h1234_5678, 1'b1, 1'b1);
    check("word3_before_reset", readdata, 32'hCAFE_F00D);
    #1 reset = 1'b1;
    model_reset();
    #1;
    check("reset_readdata_now", readdata, 32'd0);
    check_all("in_reset");
    step();
    reset = 1'b0;
    drive(2'b00, 7'h00, 3'b010, 32'd3, 32'd0, 32'h0, 1'b1, 1'b0);
    check("word3_after_reset", readdata, 32'd0);
    drive(2'b00, 7'h00, 3'b010, 32'd12, 32'd0, 32'h0, 1'b1, 1'b0);
    check("word12_after_reset", readdata, 32'd0);

    // Randomized traffic; addresses kept small most of the time so loads hit stores.
    for (int n = 0; n < 400; n++) begin
      logic [1:0]  op = 2'($urandom_range(0, 3));
      logic [6:0]  f7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) :
                        (($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20);
      logic [31:0] x, y;
      if ($urandom_range(0, 2) == 0) begin
        x = $urandom; y = $urandom;
      end else begin
        x = 32'($urandom_range(0, 31)); y = 32'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 9) == 0) y = x;
      drive(op, f7, 3'($urandom_range(0, 7)), x, y, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_all("rand");
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
